// File: rtl/demux_1to2_reg_pkg.sv
// Shared steering definitions for the demux_1to2_reg slice.
// Holds the port-select encodings and the default widths reused by the
// steering blocks (muxes and demuxes) of the datapath.
package demux_1to2_reg_pkg;

    // Port-select encodings carried on the sel input of steering blocks
    localparam logic DEMUX_SEL_P0 = 1'b0;
    localparam logic DEMUX_SEL_P1 = 1'b1;

    // Default widths for the datapath and the optional beat counters
    localparam int DEMUX_DEFAULT_WIDTH     = 32;
    localparam int DEMUX_DEFAULT_CNT_WIDTH = 16;

endpackage : demux_1to2_reg_pkg

// File: rtl/demux_slot.sv
// One-entry output holding slot for the 1-to-2 demux.
// The slot captures a beat on load and presents it until the consumer
// takes it. free tells the producer side that a load this cycle will
// not overwrite an undelivered beat: either the slot is empty, or the
// beat in it is being drained on this same edge.
module demux_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             free
);

    logic             full;
    logic [WIDTH-1:0] data;

    // Consumer side can take the current beat this cycle
    logic drain;
    assign drain = full & out_ready;

    assign free      = ~full | out_ready;
    assign out_valid = full;
    assign out_data  = data;

    // Slot state: a load wins over a drain so back-to-back beats stream
    // at one per cycle; an emptied slot keeps its last data on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset as well as the flag, because
            // the outputs must read zero while reset is held; a plain
            // datapath register would normally be left unreset.
            full <= 1'b0;
            data <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so full and data update as one atomic step.
            if (load) begin
                full <= 1'b1;
                data <= load_data;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

endmodule : demux_slot

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes.
// Steers each input beat into the output slot named by in_sel. Each
// port has its own one-entry slot, so a stalled consumer on one port
// never blocks traffic bound for the other. in_ready depends only on
// in_sel and the selected slot's state/ready, never on in_valid.
//
// Build option: define DEMUX_CNT_EN to add the per-port delivered-beat
// counters cnt0/cnt1 (CNT_WIDTH bits, wrapping). Without it the counter
// ports and logic do not exist and the datapath is unchanged.
module demux_1to2_reg
    import demux_1to2_reg_pkg::*;
#(
    parameter int WIDTH = DEMUX_DEFAULT_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_WIDTH = DEMUX_DEFAULT_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic                 out1_valid,
    input  logic                 out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    logic free0;
    logic free1;
    logic load0;
    logic load1;

    // Ready mux and load decode: only the selected slot can be loaded,
    // and only when it can take a beat on this edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the branches leaves one unassigned (no latches).
        in_ready = 1'b0;
        load0    = 1'b0;
        load1    = 1'b0;
        if (in_sel == DEMUX_SEL_P1) begin
            in_ready = free1;
            load1    = in_valid & free1;
        end else begin
            in_ready = free0;
            load0    = in_valid & free0;
        end
    end

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (in_data),
        .out_data  (out0_data),
        .out_valid (out0_valid),
        .out_ready (out0_ready),
        .free      (free0)
    );

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (in_data),
        .out_data  (out1_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .free      (free1)
    );

`ifdef DEMUX_CNT_EN
    // Delivered-beat counters: one step per output handshake, wrapping
    // naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (out1_valid && out1_ready) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule : demux_1to2_reg

// File: tb/tb_demux_1to2_reg.sv
// Directed testbench for demux_1to2_reg.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// there as well, well away from the next active edge.
module tb_demux_1to2_reg;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
`ifdef DEMUX_CNT_EN
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    demux_1to2_reg #(
        .WIDTH     (WIDTH)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_WIDTH (CNT_WIDTH)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 32'hDEADBEEF;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) cyc();
        checks++;
        if ({out0_valid, out1_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 00", {out0_valid, out1_valid});
        end
        checks++;
        if ({out0_data, out1_data} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got %h %h expected 0 0", out0_data, out1_data);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hDEADBEEF || out0_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_accept: got v1=%b d1=%h v0=%b expected 1 deadbeef 0",
                     out1_valid, out1_data, out0_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_full_not_ready: got %b expected 0", in_ready);
        end
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        cyc();
        checks++;
        if (out1_valid !== 1'b0 || out1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL reset_drain_hold: got v1=%b d1=%h expected 0 deadbeef",
                     out1_valid, out1_data);
        end
    endtask

    task automatic test_routing();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h00000011;
        cyc();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h11 || out1_valid !== 1'b0) begin
            failures++;
            $display("FAIL route_p0: got v0=%b d0=%h v1=%b expected 1 11 0",
                     out0_valid, out0_data, out1_valid);
        end
        in_sel  = 1'b1;
        in_data = 32'h00000022;
        cyc();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b1 || out1_data !== 32'h22) begin
            failures++;
            $display("FAIL route_p1: got v0=%b v1=%b d1=%h expected 0 1 22",
                     out0_valid, out1_valid, out1_data);
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out1_valid !== 1'b0) begin
            failures++;
            $display("FAIL route_p1_one_cycle: got v1=%b expected 0", out1_valid);
        end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hAAAA0001;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_a: got %b expected 1", in_ready);
        end
        cyc();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL bp_hold_a: got v0=%b d0=%h expected 1 aaaa0001", out0_valid, out0_data);
        end
        in_data = 32'hBBBB0002;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_block_b: got %b expected 0", in_ready);
        end
        cyc();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL bp_stable_a: got v0=%b d0=%h expected 1 aaaa0001", out0_valid, out0_data);
        end
        in_sel  = 1'b1;
        in_data = 32'hCCCC0003;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_c: got %b expected 1", in_ready);
        end
        cyc();
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hCCCC0003 ||
            out0_valid !== 1'b1 || out0_data !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL bp_isolation: got v1=%b d1=%h v0=%b d0=%h expected 1 cccc0003 1 aaaa0001",
                     out1_valid, out1_data, out0_valid, out0_data);
        end
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        cyc();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL bp_drain: got v0=%b v1=%b d0=%h expected 0 0 aaaa0001",
                     out0_valid, out1_valid, out0_data);
        end
    endtask

    task automatic test_back_to_back();
        out1_ready = 1'b1;
        in_sel     = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
            end
            cyc();
            checks++;
            if (out1_valid !== 1'b1 || out1_data !== WIDTH'(i)) begin
                failures++;
                $display("FAIL b2b_data[%0d]: got v1=%b d1=%h expected 1 %h",
                         i, out1_valid, out1_data, WIDTH'(i));
            end
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out1_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got v1=%b expected 0", out1_valid);
        end
    endtask

    task automatic test_mid_reset();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h00000055;
        cyc();
        in_sel  = 1'b1;
        in_data = 32'h00000066;
        cyc();
        in_valid = 1'b0;
        checks++;
        if ({out0_valid, out1_valid} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_full: got %b expected 11", {out0_valid, out1_valid});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out0_valid, out1_valid} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_async: got %b expected 00", {out0_valid, out1_valid});
        end
        #4;
        rst_n      = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (2) cyc();
        checks++;
        if ({out0_valid, out1_valid} !== 2'b00 || {out0_data, out1_data} !== 64'h0) begin
            failures++;
            $display("FAIL midrst_after: got v=%b d0=%h d1=%h expected 00 0 0",
                     {out0_valid, out1_valid}, out0_data, out1_data);
        end
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_counters();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({cnt0, cnt1} !== {CNT_WIDTH{2'b00}}) begin
            failures++;
            $display("FAIL cnt_reset: got %0d %0d expected 0 0", cnt0, cnt1);
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_data = WIDTH'(i);
            cyc();
        end
        in_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = WIDTH'(i);
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        checks++;
        if (cnt0 !== CNT_WIDTH'(1) || cnt1 !== CNT_WIDTH'(3)) begin
            failures++;
            $display("FAIL cnt_wrap: got %0d %0d expected 1 3", cnt0, cnt1);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef DEMUX_CNT_EN
        test_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_1to2_reg

// File: doc/demux_1to2_reg.md
Name: demux_1to2_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the steering counterpart of the 2-to-1 select mux.
- Routes one WIDTH-bit input beat to output port 0 or port 1, chosen by sel.
- Each output has a one-entry holding slot, so a stalled consumer on one port does not block traffic to the other.
- Used in the datapath to split store and write-back traffic between data memory and memory-mapped peripherals.

Parameters:
- WIDTH, 32, data width of the input and both outputs.
- CNT_WIDTH, 16, width of the beat counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  beat to be routed.
- in_sel  input  1  destination: 0 routes to out0, 1 routes to out1. Meaningful only while in_valid=1.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- out0_data  output  WIDTH  port-0 slot contents.
- out0_valid  output  1  port-0 slot full.
- out0_ready  input  1  port-0 consumer accepts.
- out1_data  output  WIDTH  port-1 slot contents.
- out1_valid  output  1  port-1 slot full.
- out1_ready  input  1  port-1 consumer accepts.
- cnt0, cnt1  output  CNT_WIDTH each  present only with DEMUX_CNT_EN; beats delivered per port.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous deassert is handled externally.
  - While rst_n=0: out0_valid=out1_valid=0, out0_data=out1_data=0, counters=0.
- State per port N:
  - full_N (1 bit) and data_N (WIDTH).
  - outN_valid=full_N; outN_data=data_N.
- Ready:
  - in_ready = (in_sel ? (~full_1 | out1_ready) : (~full_0 | out0_ready)).
  - Combinational from in_sel and the selected port's outN_ready; no path from in_valid.
- Accept:
  - Occurs when in_valid & in_ready.
  - Effect: data_sel<=in_data, full_sel<=1. The beat is visible on outN exactly 1 cycle after acceptance.
- Drain:
  - Occurs when outN_valid & outN_ready.
  - Effect: full_N<=0, unless an accept to the same port happens in the same cycle.
- Simultaneous drain and accept on the same port:
  - Slot stays full and takes the new data (full throughput: 1 beat/cycle per port).
- Simultaneous accept to one port and drain of the other:
  - Both take effect independently.
- Hold rules:
  - While outN_valid=1 and outN_ready=0, outN_data and outN_valid stay stable.
  - When a slot empties, outN_data holds its last value; it is not cleared.
- Ordering:
  - Order is preserved within a port.
  - No ordering is guaranteed between ports.
- No combinational path from in_data to outN_data; outputs are registered.
- Reset mid-operation: pending beats in both slots are discarded; no partial state survives.
- in_sel and in_data are don't-care when in_valid=0; the block must not change state.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Ports cnt0/cnt1 exist.
  - cntN increments by 1 on each port-N drain handshake.
  - Counters wrap modulo 2^CNT_WIDTH (all-ones + 1 -> 0) and reset to 0.
- Undefined:
  - Ports and counter logic are absent.
  - Datapath behaviour is identical.

Decomposition:
- Shared include file holds the port-select encodings DEMUX_SEL_P0=1'b0 and DEMUX_SEL_P1=1'b1 and the default widths. Other steering blocks reuse them.
- One sub-module, demux_slot: parameter WIDTH; ports clk, rst_n, load, load_data, out_data, out_valid, out_ready, free. Here free = ~full | out_ready.
- The top instantiates demux_slot twice and adds the in_ready mux, load decode and optional counters.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with in_valid=1, in_sel=1, in_data=32'hDEADBEEF.
  - Expect: out0_valid=out1_valid=0 and both data outputs 0; after release, out1_data=DEADBEEF and out1_valid=1 one cycle after the first accepted edge.
- Routing:
  - Stimulus: send 32'h00000011 with sel=0, then 32'h00000022 with sel=1, both consumers ready.
  - Expect: out0 shows 11 at cycle+1 and out1 shows 22 at cycle+2; each valid lasts 1 cycle.
- Backpressure isolation:
  - Stimulus: out0_ready=0, send A (sel=0), then B (sel=0), then C (sel=1).
  - Expect: A is held on out0; in_ready=0 for B; C is accepted and appears on out1 while out0 still holds A.
- Full throughput:
  - Stimulus: out1_ready=1, stream 8 consecutive beats 1..8 with sel=1.
  - Expect: in_ready stays 1 throughout; out1_data=1..8 on consecutive cycles with no bubbles.
- Reset mid-operation:
  - Stimulus: both slots full (out0_ready=out1_ready=0), then pulse rst_n low for half a cycle.
  - Expect: both valids drop immediately (asynchronously); no beat reappears after release.
- Counters (DEMUX_CNT_EN, CNT_WIDTH=4):
  - Stimulus: deliver 17 beats to port 0 and 3 to port 1.
  - Expect: cnt0=1 (wrapped) and cnt1=3.
